sys_cmd_initiator: RTL

SYS_CMD_INITIATOR -- requirements
Module: sys_cmd_initiator

---
 rtl/sys_cmd_pkg.sv | 52 +++++
 rtl/sys_cmd_rsp_timer.sv | 32 +++
 rtl/sys_cmd_initiator.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/sys_cmd_pkg.sv
// Shared definitions for the UART command initiator: opcodes, command and
// state encodings, and per-command TX/RX byte counts.
package sys_cmd_pkg;

  typedef enum logic [1:0] {
    CMD_WRITE = 2'b00,
    CMD_READ  = 2'b01,
    CMD_ALU   = 2'b10,
    CMD_NOP   = 2'b11
  } cmd_type_e;

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    SEND     = 2'b01,
    GAP      = 2'b10,
    WAIT_RSP = 2'b11
  } state_e;

  localparam logic [7:0] OPC_WRITE = 8'hAA;
  localparam logic [7:0] OPC_READ  = 8'hBB;
  localparam logic [7:0] OPC_ALU   = 8'hCC;
  localparam logic [7:0] OPC_NOP   = 8'hDD;

  localparam logic [2:0] TX_LEN_WRITE = 3'd3;
  localparam logic [2:0] TX_LEN_READ  = 3'd2;
  localparam logic [2:0] TX_LEN_ALU   = 3'd4;
  localparam logic [2:0] TX_LEN_NOP   = 3'd2;

  localparam logic [1:0] RX_LEN_WRITE = 2'd0;
  localparam logic [1:0] RX_LEN_READ  = 2'd1;
  localparam logic [1:0] RX_LEN_ALU   = 2'd2;
  localparam logic [1:0] RX_LEN_NOP   = 2'd2;

  function automatic logic [2:0] tx_len(input cmd_type_e t);
    case (t)
      CMD_WRITE: tx_len = TX_LEN_WRITE;
      CMD_READ:  tx_len = TX_LEN_READ;
      CMD_ALU:   tx_len = TX_LEN_ALU;
      default:   tx_len = TX_LEN_NOP;
    endcase
  endfunction

  function automatic logic [1:0] rx_len(input cmd_type_e t);
    case (t)
      CMD_WRITE: rx_len = RX_LEN_WRITE;
      CMD_READ:  rx_len = RX_LEN_READ;
      CMD_ALU:   rx_len = RX_LEN_ALU;
      default:   rx_len = RX_LEN_NOP;
    endcase
  endfunction

endpackage

// File: rtl/sys_cmd_rsp_timer.sv
// Response wait timer: cleared on entry to the wait state, counts while enabled
// and parks at LIMIT-1, where it reports expiry.
module sys_cmd_rsp_timer #(
  parameter int unsigned LIMIT = 65535
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CW = (LIMIT > 2) ? $clog2(LIMIT) : 1;

  logic [CW-1:0] cnt_r;

  assign expired = (cnt_r == CW'(LIMIT - 1));

  // Saturating cycle counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= '0;
    end else if (clear) begin
      cnt_r <= '0;
    end else if (enable && !expired) begin
      cnt_r <= cnt_r + CW'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

endmodule

// File: rtl/sys_cmd_initiator.sv
// Serialises register/ALU commands into UART bytes and assembles the reply.
// Define SYS_CMD_TIMEOUT_EN to build the response timeout (otherwise waits forever).
module sys_cmd_initiator
  import sys_cmd_pkg::*;
#(
  parameter int unsigned FRAME_WIDTH         = 8,
  parameter int unsigned REG_FILE_ADDR_WIDTH = 4,
  parameter int unsigned ALU_FUNC_WIDTH      = 4,
  parameter int unsigned RSP_TIMEOUT_CYCLES  = 65535
) (
  input  logic                           CLK,
  input  logic                           RST,
  input  logic                           CMD_VALID,
  output logic                           CMD_READY,
  input  logic [1:0]                     CMD_TYPE,
  input  logic [REG_FILE_ADDR_WIDTH-1:0] CMD_ADDR,
  input  logic [FRAME_WIDTH-1:0]         CMD_DATA,
  input  logic [FRAME_WIDTH-1:0]         CMD_OP_A,
  input  logic [FRAME_WIDTH-1:0]         CMD_OP_B,
  input  logic [ALU_FUNC_WIDTH-1:0]      CMD_FUNC,
  output logic [FRAME_WIDTH-1:0]         TX_P_DATA,
  output logic                           TX_P_VLD,
  input  logic                           TX_BUSY,
  input  logic [FRAME_WIDTH-1:0]         RX_P_DATA,
  input  logic                           RX_P_VLD,
  output logic [15:0]                    RSP_DATA,
  output logic                           RSP_VALID,
  output logic                           RSP_TIMEOUT,
  output logic                           BUSY
);

  state_e                         state_r, next_state_s;
  cmd_type_e                      type_r;
  logic [REG_FILE_ADDR_WIDTH-1:0] addr_r;
  logic [FRAME_WIDTH-1:0]         data_r, op_a_r, op_b_r;
  logic [ALU_FUNC_WIDTH-1:0]      func_r;
  logic [2:0]                     tx_idx_r;
  logic                           gap_cnt_r;
  logic [1:0]                     rx_cnt_r;
  logic [7:0]                     rx_lo_r;
  logic [15:0]                    rsp_data_r;
  logic                           rsp_valid_r, rsp_timeout_r;

  logic [2:0]             tx_len_s;
  logic [1:0]             rx_len_s;
  logic [FRAME_WIDTH-1:0] tx_byte_s;
  logic [7:0]             rx_byte_s;
  logic                   accept_s, tx_done_s, rx_take_s, rx_final_s, timeout_s;

  assign tx_len_s   = tx_len(type_r);
  assign rx_len_s   = rx_len(type_r);
  assign rx_byte_s  = RX_P_DATA[7:0];
  assign accept_s   = CMD_VALID && (state_r == IDLE);
  assign tx_done_s  = (state_r == SEND) && !TX_BUSY;
  assign rx_take_s  = (state_r == WAIT_RSP) && RX_P_VLD;
  assign rx_final_s = rx_take_s && (rx_cnt_r == (rx_len_s - 2'd1));

`ifdef SYS_CMD_TIMEOUT_EN
  logic timer_clear_s, timer_en_s, timer_expired_s;

  assign timer_clear_s = (state_r != WAIT_RSP) && (next_state_s == WAIT_RSP);
  assign timer_en_s    = (state_r == WAIT_RSP);
  assign timeout_s     = (state_r == WAIT_RSP) && timer_expired_s;

  sys_cmd_rsp_timer #(
    .LIMIT (RSP_TIMEOUT_CYCLES)
  ) u_rsp_timer (
    .clk     (CLK),
    .rst     (RST),
    .clear   (timer_clear_s),
    .enable  (timer_en_s),
    .expired (timer_expired_s)
  );
`else
  assign timeout_s = 1'b0;
`endif

  // Select the outgoing byte for the current command and byte index.
  always_comb begin
    tx_byte_s = '0;
    case (type_r)
      CMD_WRITE: begin
        case (tx_idx_r)
          3'd0:    tx_byte_s = FRAME_WIDTH'(OPC_WRITE);
          3'd1:    tx_byte_s = FRAME_WIDTH'(addr_r);
          default: tx_byte_s = data_r;
        endcase
      end
      CMD_READ: begin
        case (tx_idx_r)
          3'd0:    tx_byte_s = FRAME_WIDTH'(OPC_READ);
          default: tx_byte_s = FRAME_WIDTH'(addr_r);
        endcase
      end
      CMD_ALU: begin
        case (tx_idx_r)
          3'd0:    tx_byte_s = FRAME_WIDTH'(OPC_ALU);
          3'd1:    tx_byte_s = op_a_r;
          3'd2:    tx_byte_s = op_b_r;
          default: tx_byte_s = FRAME_WIDTH'(func_r);
        endcase
      end
      default: begin
        case (tx_idx_r)
          3'd0:    tx_byte_s = FRAME_WIDTH'(OPC_NOP);
          default: tx_byte_s = FRAME_WIDTH'(func_r);
        endcase
      end
    endcase
  end

  // Next-state logic.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (CMD_VALID) next_state_s = SEND;
        else           next_state_s = IDLE;
      end
      SEND: begin
        if (!TX_BUSY) next_state_s = GAP;
        else          next_state_s = SEND;
      end
      GAP: begin
        // gap_cnt_r is set on the second GAP cycle.
        if (gap_cnt_r) begin
          if (tx_idx_r < tx_len_s)     next_state_s = SEND;
          else if (rx_len_s != 2'd0)   next_state_s = WAIT_RSP;
          else                         next_state_s = IDLE;
        end else begin
          next_state_s = GAP;
        end
      end
      WAIT_RSP: begin
        if (rx_final_s || timeout_s) next_state_s = IDLE;
        else                         next_state_s = WAIT_RSP;
      end
      default: next_state_s = IDLE;
    endcase
  end

  // State, command capture, byte indices and response assembly.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r       <= IDLE;
      type_r        <= CMD_WRITE;
      addr_r        <= '0;
      data_r        <= '0;
      op_a_r        <= '0;
      op_b_r        <= '0;
      func_r        <= '0;
      tx_idx_r      <= 3'd0;
      gap_cnt_r     <= 1'b0;
      rx_cnt_r      <= 2'd0;
      rx_lo_r       <= 8'h00;
      rsp_data_r    <= 16'h0000;
      rsp_valid_r   <= 1'b0;
      rsp_timeout_r <= 1'b0;
    end else begin
      state_r       <= next_state_s;
      gap_cnt_r     <= (state_r == GAP) && !gap_cnt_r;
      rsp_valid_r   <= rx_final_s;
      // A final byte arriving on the expiry cycle takes precedence.
      rsp_timeout_r <= timeout_s && !rx_final_s;

      if (accept_s) begin
        type_r   <= cmd_type_e'(CMD_TYPE);
        addr_r   <= CMD_ADDR;
        data_r   <= CMD_DATA;
        op_a_r   <= CMD_OP_A;
        op_b_r   <= CMD_OP_B;
        func_r   <= CMD_FUNC;
        tx_idx_r <= 3'd0;
      end else if (tx_done_s && (tx_idx_r < tx_len_s)) begin
        tx_idx_r <= tx_idx_r + 3'd1;
      end

      if (state_r != WAIT_RSP) begin
        rx_cnt_r <= 2'd0;
      end else if (rx_take_s && (rx_cnt_r < rx_len_s)) begin
        rx_cnt_r <= rx_cnt_r + 2'd1;
      end

      if (rx_take_s && (rx_cnt_r == 2'd0)) begin
        rx_lo_r <= rx_byte_s;
      end

      if (rx_final_s) begin
        if (rx_len_s == 2'd1) rsp_data_r <= {8'h00, rx_byte_s};
        else                  rsp_data_r <= {rx_byte_s, rx_lo_r};
      end
    end
  end

  assign CMD_READY   = (state_r == IDLE);
  assign BUSY        = (state_r != IDLE);
  assign TX_P_VLD    = (state_r == SEND);
  assign TX_P_DATA   = (state_r == SEND) ? tx_byte_s : '0;
  assign RSP_DATA    = rsp_data_r;
  assign RSP_VALID   = rsp_valid_r;
  assign RSP_TIMEOUT = rsp_timeout_r;

endmodule
